// File: rtl/rcon_pkg.sv
// rcon_pkg: shared definitions for the AES round-constant generator.
//   - key_len encodings
//   - per-mode sequence lengths (10 / 8 / 7)
//   - final forward Rcon value per mode (start point of the reverse sequence)
//   - FSM state enum
//   - lookup helpers
// Optional feature macro used elsewhere in this slice: RCON_INVERSE_EN.
package rcon_pkg;

  localparam logic [1:0] KEY_LEN_128  = 2'b00;
  localparam logic [1:0] KEY_LEN_192  = 2'b01;
  localparam logic [1:0] KEY_LEN_256  = 2'b10;
  localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

  localparam logic [3:0] LIMIT_128 = 4'd10;
  localparam logic [3:0] LIMIT_192 = 4'd8;
  localparam logic [3:0] LIMIT_256 = 4'd7;

  localparam logic [7:0] FINAL_128 = 8'h36;
  localparam logic [7:0] FINAL_192 = 8'h80;
  localparam logic [7:0] FINAL_256 = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Number of round constants for a key length; the reserved code behaves as AES-128.
  function automatic logic [3:0] limit_of(input logic [1:0] key_len);
    logic [3:0] lim;
    case (key_len)
      KEY_LEN_128: lim = LIMIT_128;
      KEY_LEN_192: lim = LIMIT_192;
      KEY_LEN_256: lim = LIMIT_256;
      default:     lim = LIMIT_128;
    endcase
    return lim;
  endfunction

  // Last forward round constant for a key length (first value when running in reverse).
  function automatic logic [7:0] final_of(input logic [1:0] key_len);
    logic [7:0] val;
    case (key_len)
      KEY_LEN_128: val = FINAL_128;
      KEY_LEN_192: val = FINAL_192;
      KEY_LEN_256: val = FINAL_256;
      default:     val = FINAL_128;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/rcon_seq_gen_gf_xtime.sv
// gf_xtime: combinational GF(2^8) multiply-by-x, reduced by POLY.
// With RCON_INVERSE_EN defined, an extra input selects the inverse
// operation (divide by x), used to walk the Rcon sequence backwards.
// Ports:
//   a   in  8  operand
//   inv in  1  (RCON_INVERSE_EN only) 1 = divide by x
//   y   out 8  result
module gf_xtime
  import rcon_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic [7:0] a,
`ifdef RCON_INVERSE_EN
  input  logic       inv,
`endif
  output logic [7:0] y
);

  logic [7:0] fwd_s;

  assign fwd_s = {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);

`ifdef RCON_INVERSE_EN
  logic [7:0] rev_s;

  // An odd value can only come from a reduced shift, so undo the reduction
  // and restore the bit that fell off the top.
  assign rev_s = a[0] ? (((a ^ POLY) >> 3'd1) | 8'h80) : (a >> 3'd1);

  // Select multiply or divide by x.
  always_comb begin
    if (inv) begin
      y = rev_s;
    end else begin
      y = fwd_s;
    end
  end
`else
  // Forward-only build: multiply by x.
  always_comb begin
    y = fwd_s;
  end
`endif

endmodule

// File: rtl/rcon_seq_gen.sv
// rcon_seq_gen: sequential AES round-constant generator.
// Emits one Rcon value per valid/ready handshake after a start pulse;
// each value is derived from the previous one by GF(2^8) xtime.
// Optional feature macro: RCON_INVERSE_EN (adds 'dir' for reverse order).
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin (or restart) a sequence
//   key_len    in   2      00=128, 01=192, 10=256, 11=treated as 128
//   rcon_ready in   1      consumer accepts current value
//   dir        in   1      (RCON_INVERSE_EN only) 1 = reverse sequence
//   rcon_valid out  1      rcon holds a valid value
//   rcon       out  8      current round constant
//   rcon_idx   out  IDX_W  1-based index of current value
//   rcon_last  out  1      current value is the final one
//   done       out  1      one-cycle pulse after last value accepted
//   busy       out  1      sequence in progress
module rcon_seq_gen
  import rcon_pkg::*;
#(
  parameter logic [7:0] POLY      = 8'h1B,
  parameter logic [7:0] RCON_INIT = 8'h01,
  parameter int         IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             rcon_ready,
`ifdef RCON_INVERSE_EN
  input  logic             dir,
`endif
  output logic             rcon_valid,
  output logic [7:0]       rcon,
  output logic [IDX_W-1:0] rcon_idx,
  output logic             rcon_last,
  output logic             done,
  output logic             busy
);

  state_e           state_r, state_n;
  logic [7:0]       rcon_r, rcon_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [IDX_W-1:0] limit_r, limit_n;
  logic             valid_r, valid_n;
  logic             last_r, last_n;
  logic             done_r, done_n;
  logic             busy_r, busy_n;

  logic [7:0]       step_s;
  logic [IDX_W-1:0] idx_step_s;
  logic [IDX_W-1:0] end_idx_s;
  logic [IDX_W-1:0] start_limit_s;
  logic             handshake_s;

  assign start_limit_s = IDX_W'(limit_of(key_len));
  assign handshake_s   = valid_r & rcon_ready;

`ifdef RCON_INVERSE_EN
  logic dir_r, dir_n;

  // Reverse mode counts the index down and finishes at 1.
  assign idx_step_s = dir_r ? (idx_r - IDX_W'(1)) : (idx_r + IDX_W'(1));
  assign end_idx_s  = dir_r ? IDX_W'(1) : limit_r;

  gf_xtime #(.POLY(POLY)) u_xtime (
    .a   (rcon_r),
    .inv (dir_r),
    .y   (step_s)
  );
`else
  assign idx_step_s = idx_r + IDX_W'(1);
  assign end_idx_s  = limit_r;

  gf_xtime #(.POLY(POLY)) u_xtime (
    .a (rcon_r),
    .y (step_s)
  );
`endif

  // Next-state and next-output logic; start overrides any same-cycle handshake.
  always_comb begin
    state_n = state_r;
    rcon_n  = rcon_r;
    idx_n   = idx_r;
    limit_n = limit_r;
    valid_n = valid_r;
    last_n  = last_r;
    done_n  = 1'b0;
    busy_n  = busy_r;
`ifdef RCON_INVERSE_EN
    dir_n   = dir_r;
`endif

    if (start) begin
      state_n = ST_RUN;
      limit_n = start_limit_s;
      valid_n = 1'b1;
      last_n  = 1'b0;
      busy_n  = 1'b1;
`ifdef RCON_INVERSE_EN
      dir_n   = dir;
      if (dir) begin
        rcon_n = final_of(key_len);
        idx_n  = start_limit_s;
      end else begin
        rcon_n = RCON_INIT;
        idx_n  = IDX_W'(1);
      end
`else
      rcon_n  = RCON_INIT;
      idx_n   = IDX_W'(1);
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          busy_n  = 1'b0;
        end
        ST_RUN: begin
          if (handshake_s) begin
            if (last_r) begin
              // rcon keeps its final value; it is don't-care while invalid.
              state_n = ST_DONE;
              valid_n = 1'b0;
              last_n  = 1'b0;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end else begin
              rcon_n  = step_s;
              idx_n   = idx_step_s;
              last_n  = (idx_step_s == end_idx_s);
            end
          end else begin
            state_n = ST_RUN;
          end
        end
        ST_DONE: begin
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
          last_n  = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rcon_r  <= 8'h00;
      idx_r   <= '0;
      limit_r <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef RCON_INVERSE_EN
      dir_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      rcon_r  <= rcon_n;
      idx_r   <= idx_n;
      limit_r <= limit_n;
      valid_r <= valid_n;
      last_r  <= last_n;
      done_r  <= done_n;
      busy_r  <= busy_n;
`ifdef RCON_INVERSE_EN
      dir_r   <= dir_n;
`endif
    end
  end

  assign rcon_valid = valid_r;
  assign rcon       = rcon_r;
  assign rcon_idx   = idx_r;
  assign rcon_last  = last_r;
  assign done       = done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_rcon_seq_gen.sv
// Self-checking bench for rcon_seq_gen: a table-driven AES-128 run plus
// hand-written sequences for back-to-back modes, backpressure, restart,
// reserved key_len and asynchronous reset.
module tb_rcon_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] key_len = 2'b00;
  logic       rcon_ready = 1'b0;
`ifdef RCON_INVERSE_EN
  logic       dir = 1'b0;
`endif
  logic       rcon_valid;
  logic [7:0] rcon;
  logic [3:0] rcon_idx;
  logic       rcon_last;
  logic       done;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Forward AES Rcon sequence, written out by hand.
  logic [7:0] exp_vals [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  typedef struct {
    logic       start;
    logic [1:0] key_len;
    logic       ready;
    logic       valid;
    logic [7:0] rcon;
    logic [3:0] idx;
    logic       last;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  rcon_seq_gen #(.POLY(8'h1B), .RCON_INIT(8'h01), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_len    (key_len),
    .rcon_ready (rcon_ready),
`ifdef RCON_INVERSE_EN
    .dir        (dir),
`endif
    .rcon_valid (rcon_valid),
    .rcon       (rcon),
    .rcon_idx   (rcon_idx),
    .rcon_last  (rcon_last),
    .done       (done),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input logic [7:0] r, input logic [3:0] i, input logic l);
    chk({nm, " valid"}, 32'(rcon_valid), 32'(1'b1));
    chk({nm, " rcon"},  32'(rcon),       32'(r));
    chk({nm, " idx"},   32'(rcon_idx),   32'(i));
    chk({nm, " last"},  32'(rcon_last),  32'(l));
    chk({nm, " done"},  32'(done),       32'(1'b0));
    chk({nm, " busy"},  32'(busy),       32'(1'b1));
  endtask

  task automatic expect_done(input string nm);
    chk({nm, " valid"}, 32'(rcon_valid), 32'(1'b0));
    chk({nm, " last"},  32'(rcon_last),  32'(1'b0));
    chk({nm, " done"},  32'(done),       32'(1'b1));
    chk({nm, " busy"},  32'(busy),       32'(1'b0));
  endtask

  task automatic expect_reset(input string nm);
    chk({nm, " valid"}, 32'(rcon_valid), 32'(1'b0));
    chk({nm, " rcon"},  32'(rcon),       32'(8'h00));
    chk({nm, " idx"},   32'(rcon_idx),   32'(4'd0));
    chk({nm, " last"},  32'(rcon_last),  32'(1'b0));
    chk({nm, " done"},  32'(done),       32'(1'b0));
    chk({nm, " busy"},  32'(busy),       32'(1'b0));
  endtask

  // Start a run, change key_len right after (must not matter), consume n values, see done.
  task automatic run_mode(input string nm, input logic [1:0] kl, input int n);
    start = 1'b1;
    key_len = kl;
    rcon_ready = 1'b1;
    tick();
    start = 1'b0;
    key_len = ~kl;
    for (int k = 0; k < n; k++) begin
      expect_val($sformatf("%s v%0d", nm, k + 1), exp_vals[k], 4'(k + 1), (k == n - 1));
      tick();
    end
    expect_done({nm, " end"});
  endtask

  initial begin
    // AES-128 with ready high: start row, ten values, done pulse, back to idle.
    vecs[0] = '{1'b1, 2'b00, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k < 10; k++) begin
      vecs[k] = '{1'b0, 2'b00, 1'b1, 1'b1, exp_vals[k], 4'(k + 1), (k == 9), 1'b0, 1'b1};
    end
    vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    tick();
    tick();
    expect_reset("reset");
    rst_n = 1'b1;

    // Ready while nothing is valid is ignored.
    rcon_ready = 1'b1;
    tick();
    chk("idle ready valid", 32'(rcon_valid), 32'(1'b0));
    chk("idle ready busy",  32'(busy),       32'(1'b0));

    // Table-driven AES-128 run.
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start;
      key_len = vecs[i].key_len;
      rcon_ready = vecs[i].ready;
      tick();
      chk($sformatf("tbl%0d valid", i), 32'(rcon_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("tbl%0d rcon", i), 32'(rcon),     32'(vecs[i].rcon));
        chk($sformatf("tbl%0d idx", i),  32'(rcon_idx), 32'(vecs[i].idx));
      end else begin
        chk($sformatf("tbl%0d idle-state", i), 32'(dut.state_r == rcon_pkg::ST_RUN), 32'(1'b0));
      end
      chk($sformatf("tbl%0d last", i), 32'(rcon_last), 32'(vecs[i].last));
      chk($sformatf("tbl%0d done", i), 32'(done),      32'(vecs[i].done));
      chk($sformatf("tbl%0d busy", i), 32'(busy),      32'(vecs[i].busy));
    end

    // AES-192 then AES-256 back to back (second start lands in the done cycle).
    run_mode("aes192", 2'b01, 8);
    run_mode("aes256", 2'b10, 7);
    tick();
    chk("post256 done", 32'(done), 32'(1'b0));
    chk("post256 valid", 32'(rcon_valid), 32'(1'b0));

    // Backpressure: hold at 08 / idx 4 for three cycles.
    start = 1'b1;
    key_len = 2'b00;
    rcon_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_val($sformatf("bp pre%0d", k), exp_vals[k], 4'(k + 1), 1'b0);
      tick();
    end
    expect_val("bp 08", 8'h08, 4'd4, 1'b0);
    rcon_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_val($sformatf("bp hold%0d", k), 8'h08, 4'd4, 1'b0);
    end
    rcon_ready = 1'b1;
    tick();
    expect_val("bp resume", 8'h10, 4'd5, 1'b0);
    tick();
    expect_val("bp idx6", 8'h20, 4'd6, 1'b0);

    // Restart at idx 6 with reserved key_len: full 10-value run, no early done.
    start = 1'b1;
    key_len = 2'b11;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_val($sformatf("rsvd v%0d", k + 1), exp_vals[k], 4'(k + 1), (k == 9));
      tick();
    end
    expect_done("rsvd end");
    tick();

    // Asynchronous reset mid-sequence at idx 5.
    start = 1'b1;
    key_len = 2'b00;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    expect_val("arst pre", 8'h10, 4'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset("arst now");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst after done",  32'(done),       32'(1'b0));
    chk("arst after valid", 32'(rcon_valid), 32'(1'b0));
    chk("arst after busy",  32'(busy),       32'(1'b0));

`ifdef RCON_INVERSE_EN
    // Reverse AES-128 sequence.
    dir = 1'b1;
    start = 1'b1;
    key_len = 2'b00;
    tick();
    start = 1'b0;
    dir = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_val($sformatf("inv v%0d", k + 1), exp_vals[9 - k], 4'(10 - k), (k == 9));
      tick();
    end
    expect_done("inv end");
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rcon_seq_gen.md
Name: rcon_seq_gen

Overview:
- Sequential AES round-constant generator; replaces the fixed ten-entry constant table.
- Supports AES-128, AES-192 and AES-256 key schedules, selected at run time.
- Emits Rcon values one per handshake to the key-expansion FSM; each value is computed by GF(2^8) xtime rather than stored.
- Sits between the key-schedule controller and its SubWord/RotWord datapath.

Parameters:
POLY, 8'h1B, low byte of the GF(2^8) reduction polynomial used by xtime.
RCON_INIT, 8'h01, first Rcon value emitted after start.
IDX_W, 4, width of the round-index output; must be at least 4.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a new sequence.
key_len  input  2  sampled on start: 00=AES-128 (10 values), 01=AES-192 (8), 10=AES-256 (7), 11=reserved, treated as 00.
rcon_ready  input  1  consumer accepts the current value.
rcon_valid  output  1  rcon holds a valid value.
rcon  output  8  current round constant.
rcon_idx  output  IDX_W  1-based index of the current value.
rcon_last  output  1  current value is the final one for the sampled key_len.
done  output  1  one-cycle pulse after the last value is accepted.
busy  output  1  high from the cycle after start until done.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: rcon=8'h00, rcon_valid=0, rcon_idx=0, rcon_last=0, done=0, busy=0, FSM=IDLE. Reset asserted mid-sequence aborts it immediately; no done pulse.
- FSM states:
  - IDLE: on start, go to RUN.
  - RUN: on handshake (rcon_valid & rcon_ready) with rcon_last=1, go to DONE.
  - DONE: lasts one cycle; done=1, busy=0; then go to IDLE.
- Start, cycle t:
  - Latch the limit: 10, 8 or 7 per key_len.
  - Cycle t+1: rcon=RCON_INIT, rcon_idx=1, rcon_valid=1, busy=1.
- Advance on handshake:
  - Next cycle: rcon = {rcon[6:0],1'b0} ^ (rcon[7] ? POLY : 8'h00); rcon_idx increments.
  - No bubbles: ready held high gives one value per cycle.
- Backpressure: while rcon_valid=1 and rcon_ready=0, rcon, rcon_idx and rcon_last hold stable.
- rcon_last = rcon_valid & (rcon_idx == limit), registered in step with rcon.
- Final handshake: the next cycle has rcon_valid=0, rcon_last=0, done=1. rcon keeps its last value; it is don't-care while invalid.
- start while in RUN or DONE: restart. start takes priority over a same-cycle handshake. No done pulse for the aborted sequence.
- Changes to key_len after start have no effect until the next start.
- rcon_ready while rcon_valid=0: ignored.

Optional Feature:
Macro RCON_INVERSE_EN.
- Defined:
  - Adds input `dir` (1 bit), sampled on start. dir=0 gives forward operation.
  - dir=1 emits the sequence in reverse for the decryption key schedule.
  - The first value is the final forward value: 8'h36, 8'h80 or 8'h40 for AES-128, -192, -256. It comes from a package constant lookup.
  - Each handshake applies inverse xtime: rcon[0] ? (((rcon ^ POLY) >> 1) | 8'h80) : (rcon >> 1).
  - rcon_idx counts down from the limit to 1; rcon_last is asserted at idx 1.
- Undefined:
  - Port `dir` is absent; the block is forward only.
  - No inverse logic is synthesised.

Decomposition:
- Package rcon_pkg holds:
  - key_len encoding localparams;
  - per-mode limit constants (10/8/7);
  - final-value constants (36/80/40);
  - FSM state enum.
- One natural sub-module, gf_xtime: a combinational 8-bit xtime (with inverse when RCON_INVERSE_EN is defined), parameterised by POLY and instantiated once.

Test Plan:
- AES-128, ready tied high, start at t:
  - values 01,02,04,08,10,20,40,80,1B,36 on cycles t+1..t+10, idx 1..10;
  - rcon_last only with 36; done=1 at t+11; busy low at t+11.
- AES-192 then AES-256 back-to-back:
  - 8 values ending with 80 (last=1), done;
  - then a new start giving 7 values ending with 40.
- Backpressure:
  - ready=0 for 3 cycles while rcon=08 (idx 4): rcon, idx and valid stay stable;
  - after ready rises, next value is 10 with no duplication or skip.
- Restart and reserved mode:
  - start again at idx 6 with key_len=11: next cycle rcon=01, idx=1, limit 10;
  - no done pulse for the aborted run.
- Reset mid-sequence: rst_n low at idx 5, asynchronously mid-cycle; all outputs go to reset values at once; no done pulse.
- With RCON_INVERSE_EN, dir=1, AES-128: 36,1B,80,40,20,10,08,04,02,01 with idx 10..1; last at idx 1.
